// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
//   state_e       : controller states (IDLE / RUN / DONE)
//   digit_e       : Booth digit selection, one of {0, +1, +2, -1, -2} x multiplicand
//   booth_decode  : maps a 3-bit window {m[1], m[0], m_prev} to a digit
//   n_digits      : number of digits retired per operation
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_e;

  function automatic digit_e booth_decode(input logic [2:0] win);
    digit_e d;
    case (win)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

  // Unsigned operands are zero-extended by two bits, which costs one extra
  // digit so the top window sees a zero sign.
  function automatic int n_digits(input int a_w, input logic signed_mode);
    return signed_mode ? (a_w / 2) : (a_w / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth partial-product generator.
//   win         : {m[1], m[0], m_prev} recoding window
//   mc          : multiplicand
//   signed_mode : 1 = sign-extend mc, 0 = zero-extend mc
//   pp          : selected partial product (0, +-mc, +-2mc), A_W+B_W+2 bits
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int A_W = 12,
  parameter int B_W = 12
) (
  input  logic [2:0]         win,
  input  logic [B_W-1:0]     mc,
  input  logic               signed_mode,
  output logic [A_W+B_W+1:0] pp
);

  localparam int PW = A_W + B_W + 2;

  logic [PW-1:0] mc_ext;

  always_comb begin
    mc_ext = {{(PW - B_W){signed_mode & mc[B_W-1]}}, mc};
    case (booth_decode(win))
      DIG_P1:  pp = mc_ext;
      DIG_P2:  pp = mc_ext << 1;
      DIG_M1:  pp = -mc_ext;
      DIG_M2:  pp = -(mc_ext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one Booth digit retired per clock into a
// shared accumulator. Produces the full product and a rounded (half-up),
// saturated Q-format result.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : launch; honoured only in IDLE or DONE
//   clear          : synchronous abort to IDLE, keeps last completed outputs
//   signed_mode    : 1 = two's complement, 0 = unsigned (latched with start)
//   mult_1, mult_2 : multiplier (Booth-recoded) and multiplicand
//   busy           : high while digits remain to be retired
//   result         : full A_W+B_W product, held until next completion
//   result_scaled  : round(product / 2^FRAC), clamped to OUT_W bits
//   overflow       : clamp applied to result_scaled
//   result_rdy     : one-cycle pulse in the DONE cycle
//   dbg_state      : current controller state
//
// Handshake: start is a request sampled on a rising edge while the block is in
// IDLE or DONE; it is ignored otherwise. Exactly N edges later result_rdy is
// high for one cycle together with valid result/result_scaled/overflow; there
// is no backpressure. Asserting start in the DONE cycle chains the next
// operation with no idle cycle.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int A_W   = 12,
  parameter int B_W   = 12,
  parameter int FRAC  = 11,
  parameter int OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 signed_mode,
  input  logic [A_W-1:0]       mult_1,
  input  logic [B_W-1:0]       mult_2,
  output logic                 busy,
  output logic [A_W+B_W-1:0]   result,
  output logic [OUT_W-1:0]     result_scaled,
  output logic                 overflow,
  output logic                 result_rdy,
  output logic [1:0]           dbg_state
);

  localparam int W     = A_W + B_W;
  localparam int ACC_W = W + 2;
  localparam int SH_W  = W + 1 - FRAC;
  localparam int CNT_W = $clog2(A_W / 2 + 2);
  localparam logic [W:0] RND =
    (FRAC > 0) ? ((W + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic [OUT_W-1:0] S_MIN = OUT_W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] S_MAX = ~S_MIN;

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [A_W+1:0]   mreg;
  logic             m_prev;
  logic [B_W-1:0]   mc;
  logic             smode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [ACC_W-1:0] pp;
  logic [ACC_W-1:0] acc_next;

  booth_r4_digit #(
    .A_W(A_W),
    .B_W(B_W)
  ) u_digit (
    .win        ({mreg[1:0], m_prev}),
    .mc         (mc),
    .signed_mode(smode),
    .pp         (pp)
  );

  // Wrap-around above ACC_W is harmless: the true product fits in W bits.
  assign acc_next  = acc + (pp << {cnt, 1'b0});
  assign last_cnt  = CNT_W'(n_digits(A_W, smode) - 1);
  assign dbg_state = state;

  // Rounding and saturation of the product that completes on this edge.
  logic [W:0]       prod_ext;
  logic [W:0]       tmp;
  logic [SH_W-1:0]  sh;
  logic [OUT_W-1:0] scaled;
  logic             sat;

  always_comb begin
    prod_ext = {smode & acc_next[W-1], acc_next[W-1:0]};
    tmp      = prod_ext + RND;
    // tmp is already sign/zero extended, so dropping the low FRAC bits is the
    // arithmetic (signed) or logical (unsigned) shift.
    sh       = tmp[W:FRAC];
    scaled   = sh[OUT_W-1:0];
    sat      = 1'b0;
    if (smode) begin
      if (sh[SH_W-1:OUT_W-1] != {(SH_W - OUT_W + 1){sh[SH_W-1]}}) begin
        sat    = 1'b1;
        scaled = sh[SH_W-1] ? S_MIN : S_MAX;
      end
    end else if (|sh[SH_W-1:OUT_W]) begin
      sat    = 1'b1;
      scaled = '1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{acc_next[ACC_W-1:W], tmp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      mreg          <= '0;
      m_prev        <= 1'b0;
      mc            <= '0;
      smode         <= 1'b0;
      cnt           <= '0;
      busy          <= 1'b0;
      result        <= '0;
      result_scaled <= '0;
      overflow      <= 1'b0;
      result_rdy    <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy <= 1'b0;
          if (start) begin
            state  <= RUN;
            acc    <= '0;
            cnt    <= '0;
            mreg   <= {{2{signed_mode & mult_1[A_W-1]}}, mult_1};
            m_prev <= 1'b0;
            mc     <= mult_2;
            smode  <= signed_mode;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mreg   <= mreg >> 2;
          m_prev <= mreg[1];
          cnt    <= cnt + 1'b1;
          if (cnt == last_cnt) begin
            state         <= DONE;
            busy          <= 1'b0;
            result        <= acc_next[W-1:0];
            result_scaled <= scaled;
            overflow      <= sat;
            result_rdy    <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
module tb_booth_r4_seq_mult;

  localparam int A_W   = 12;
  localparam int B_W   = 12;
  localparam int FRAC  = 11;
  localparam int OUT_W = 12;
  localparam int W     = A_W + B_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             signed_mode = 1'b0;
  logic [A_W-1:0]   mult_1 = '0;
  logic [B_W-1:0]   mult_2 = '0;
  logic             busy;
  logic [W-1:0]     result;
  logic [OUT_W-1:0] result_scaled;
  logic             overflow;
  logic             result_rdy;
  logic [1:0]       dbg_state;

  booth_r4_seq_mult #(
    .A_W(A_W), .B_W(B_W), .FRAC(FRAC), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .signed_mode(signed_mode), .mult_1(mult_1), .mult_2(mult_2),
    .busy(busy), .result(result), .result_scaled(result_scaled),
    .overflow(overflow), .result_rdy(result_rdy), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int               t0;
    int               due;
    logic [W-1:0]     res;
    logic [OUT_W-1:0] sc;
    logic             ov;
  } op_t;

  op_t exp_q[$];
  logic [W-1:0]     h_res = '0;
  logic [OUT_W-1:0] h_sc  = '0;
  logic             h_ov  = 1'b0;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference: plain integer arithmetic.
  function automatic op_t model(input logic sm, input logic [A_W-1:0] a,
                                input logic [B_W-1:0] b, input int t0);
    op_t o;
    longint av, bv, p, s;
    av = sm ? longint'($signed(a)) : longint'(a);
    bv = sm ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    s  = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
    o.ov = 1'b0;
    if (sm) begin
      if (s > (longint'(1) << (OUT_W - 1)) - 1) begin
        s = (longint'(1) << (OUT_W - 1)) - 1; o.ov = 1'b1;
      end else if (s < -(longint'(1) << (OUT_W - 1))) begin
        s = -(longint'(1) << (OUT_W - 1)); o.ov = 1'b1;
      end
    end else if (s > (longint'(1) << OUT_W) - 1) begin
      s = (longint'(1) << OUT_W) - 1; o.ov = 1'b1;
    end
    o.res = W'(p);
    o.sc  = OUT_W'(s);
    o.t0  = t0;
    o.due = t0 + A_W / 2 + (sm ? 0 : 1);
    return o;
  endfunction

  // ---------------- compare process ----------------
  logic exp_rdy, exp_busy;
  op_t  cur;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_rdy  = 1'b0;
      exp_busy = 1'b0;
      if (exp_q.size() > 0) begin
        exp_rdy  = (exp_q[0].due == cyc);
        exp_busy = (cyc > exp_q[0].t0) && (cyc < exp_q[0].due);
      end
      chk("result_rdy", 64'(result_rdy), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_rdy) begin
        cur   = exp_q.pop_front();
        h_res = cur.res;
        h_sc  = cur.sc;
        h_ov  = cur.ov;
      end
      chk("result", 64'(result), 64'(h_res));
      chk("result_scaled", 64'(result_scaled), 64'(h_sc));
      chk("overflow", 64'(overflow), 64'(h_ov));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Called at negedge+1; the DUT must be in IDLE or DONE.
  task automatic issue(input logic sm, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    start       = 1'b1;
    signed_mode = sm;
    mult_1      = a;
    mult_2      = b;
    exp_q.push_back(model(sm, a, b, cyc + 1));
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: timeout with %0d ops pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_held(input string name, input logic [W-1:0] r,
                          input logic [OUT_W-1:0] s, input logic o);
    chk({name, "_res"}, 64'(result), 64'(r));
    chk({name, "_sc"}, 64'(result_scaled), 64'(s));
    chk({name, "_ov"}, 64'(overflow), 64'(o));
  endtask

  function automatic logic [A_W-1:0] pick();
    case ($urandom_range(0, 9))
      0:       return 12'h800;
      1:       return 12'h7FF;
      2:       return 12'h000;
      3:       return 12'hFFF;
      4:       return 12'h001;
      default: return 12'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  op_t m;
  initial begin
    // Pin the model against hand-computed values.
    m = model(1'b1, 12'h800, 12'h800, 0);
    chk("model_ss_res", 64'(m.res), 64'h400000);
    chk("model_ss_sc", 64'(m.sc), 64'h7FF);
    m = model(1'b1, 12'd1000, 12'hFFD, 0);
    chk("model_neg_res", 64'(m.res), 64'hFFF448);
    chk("model_neg_sc", 64'(m.sc), 64'hFFF);
    m = model(1'b0, 12'hFFF, 12'hFFF, 0);
    chk("model_uu_res", 64'(m.res), 64'hFFE001);
    chk("model_uu_due", 64'(m.due), 64'd7);

    // Reset state.
    repeat (3) step();
    chk_held("reset", '0, '0, 1'b0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rdy", 64'(result_rdy), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors.
    issue(1'b1, 12'h800, 12'h800);
    wait_idle();
    chk_held("min_x_min", 24'h400000, 12'h7FF, 1'b1);
    step();

    issue(1'b1, 12'd1000, 12'hFFD);
    wait_idle();
    chk_held("k_x_m3", 24'hFFF448, 12'hFFF, 1'b0);
    step();

    issue(1'b0, 12'hFFF, 12'hFFF);
    wait_idle();
    chk_held("umax", 24'hFFE001, 12'hFFF, 1'b1);
    step();

    // start held through RUN with different operands: only the first counts.
    start = 1'b1; signed_mode = 1'b1; mult_1 = 12'd100; mult_2 = 12'd7;
    exp_q.push_back(model(1'b1, 12'd100, 12'd7, cyc + 1));
    step();
    mult_1 = 12'h123; mult_2 = 12'h456; signed_mode = 1'b0;
    repeat (3) step();
    start = 1'b0;
    wait_idle();
    chk_held("held_start", 24'd700, 12'd0, 1'b0);
    // Still in the DONE cycle: chain the next operation with no gap.
    issue(1'b1, 12'd3, 12'd5);
    wait_idle();
    chk_held("b2b", 24'd15, 12'd0, 1'b0);

    // clear during RUN (with start asserted alongside): nothing delivered.
    issue(1'b1, 12'd5, 12'd9);
    step();
    clear = 1'b1; start = 1'b1; mult_1 = 12'd77; mult_2 = 12'd2;
    exp_q.delete();
    step();
    clear = 1'b0; start = 1'b0;
    repeat (10) step();
    chk_held("after_clear", 24'd15, 12'd0, 1'b0);

    // Asynchronous reset mid-RUN.
    issue(1'b1, 12'h7FF, 12'h7FF);
    repeat (2) step();
    rst_n = 1'b0;
    exp_q.delete();
    h_res = '0; h_sc = '0; h_ov = 1'b0;
    #1;
    chk_held("mid_reset", '0, '0, 1'b0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_rdy", 64'(result_rdy), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(1'b1, 12'hFF9, 12'd9);
    wait_idle();
    chk_held("post_reset", 24'hFFFFC1, 12'd0, 1'b0);

    // Mixed-mode operand sweep including corner values.
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) step();
      issue(1'($urandom_range(0, 1)), pick(), pick());
      wait_idle();
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Parametrised, iterative radix-4 Booth multiplier for the FFT butterfly datapath.
- Each cycle it retires one Booth digit into a shared accumulator, trading latency for area so one instance can serve a time-multiplexed butterfly.
- Signed and unsigned operand modes are selected per operation.
- Emits the full-width product plus a rounded, saturated Q-format result for twiddle scaling, with start/busy/rdy handshake and synchronous abort.

Parameters:
- A_W, 12, multiplier (mult_1) width; must be even, >=4
- B_W, 12, multiplicand (mult_2) width, >=2
- FRAC, 11, fractional bits dropped for result_scaled; 0 = no rounding
- OUT_W, 12, result_scaled width, <= A_W+B_W-FRAC

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE or DONE
- clear  in  1  synchronous abort, highest priority after reset
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with start
- mult_1  in  A_W  multiplier (Booth-recoded operand); latched with start
- mult_2  in  B_W  multiplicand; latched with start
- busy  out  1  high in RUN
- result  out  A_W+B_W  full product; held until next completion
- result_scaled  out  OUT_W  rounded, saturated product>>FRAC
- overflow  out  1  saturation occurred on result_scaled
- result_rdy  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, result, result_scaled, overflow, result_rdy all 0; accumulator and counter cleared.
- Digit count N: A_W/2 when signed_mode=1; A_W/2+1 when signed_mode=0 (multiplier zero-extended by 2 bits).
- FSM states IDLE, RUN, DONE:
  - IDLE -start-> RUN; latch operands, acc=0, cnt=0.
  - RUN: on each edge, digit d in {-2..+2} from bits {m[1],m[0],m_prev}; acc += (d*mc) << 2*cnt. Multiplier register shifts right by 2; cnt++.
  - After N RUN edges -> DONE. result, result_scaled and overflow are registered on that edge.
  - DONE: result_rdy=1 for exactly this cycle. start here -> RUN with no bubble (back-to-back); otherwise -> IDLE.
- Latency: start sampled at edge t0; result_rdy is high in the cycle after edge t0+N. busy is high after edges t0+1..t0+N-1, low in DONE.
- start while busy: ignored, with no effect on operands in flight.
- clear in any state -> IDLE next edge:
  - result_rdy is not pulsed.
  - result, result_scaled and overflow keep their last completed values.
  - clear and start in the same cycle: clear wins.
- Reset mid-operation: immediate IDLE and outputs cleared; the operation is lost.
- Multiplicand extension: mc is sign-extended (signed) or zero-extended (unsigned) to A_W+B_W+2 bits. The accumulator is A_W+B_W+2 bits; result is its low A_W+B_W bits, which is exact for both modes.
- Scaling:
  - tmp = product + (FRAC>0 ? 1<<(FRAC-1) : 0), i.e. round-half-up, computed at A_W+B_W+1 bits.
  - Shift is arithmetic in signed mode, logical in unsigned mode.
  - Clamp signed to [-2^(OUT_W-1), 2^(OUT_W-1)-1], unsigned to [0, 2^OUT_W-1].
  - overflow=1 when a clamp was applied.

Decomposition:
- Shared package booth_pkg: FSM state enum (IDLE/RUN/DONE), Booth digit encoding constants, function n_digits(A_W, signed_mode).
- One natural combinational sub-module, booth_r4_digit: inputs a 3-bit window, mc and signed flag; output the selected partial product (0, ±mc, ±2mc) at A_W+B_W+2 bits.

Test Plan:
- Signed -2048 × -2048 -> result 0x400000 after N=6 RUN cycles; result_scaled 2047, overflow=1.
- Signed 1000 × -3 -> result 0xFFF448; result_scaled 0xFFF (-1), overflow=0; result_rdy a single-cycle pulse, busy high 5 cycles before it.
- Unsigned 4095 × 4095 -> result 0xFFE001 with N=7; result_scaled 4095, overflow=1.
- start held during RUN with new operands -> first product unaffected. start in the DONE cycle with 3 × 5 (signed) -> 15 delivered N cycles later with no idle gap.
- clear at RUN cycle 3 -> no result_rdy, prior result held. rst_n low mid-RUN -> all outputs 0 immediately; a fresh op after release completes correctly.
- 2000 random operand pairs, mixed signed_mode, including min/max/zero -> result and result_scaled match a behavioural reference model bit-exactly.
